// File: rtl/double_to_sig16b.sv
// Converts an IEEE-754 double into a 16-bit sign-magnitude codec sample (one shift bit per cycle).
// Latency: 2 edges for special/out-of-range operands, 17-E edges for 0<=E<=14 (E = unbiased exponent).
// No backpressure: start is accepted every cycle and aborts any conversion in flight.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset, overrides all other inputs
//   start   one-cycle load strobe, samples double
//   double  IEEE-754 double operand (bits [36:0] are not used)
//   sig16b  result, [15] sign, [14:0] magnitude
//   stop    done level, high from result write until the next start or rst
//   ovf     saturation / invalid flag, meaningful while stop=1
//
// Build option: D2S_ROUND_EN selects round-to-nearest (ties away from zero) via the
// guard bit; without it the conversion truncates toward zero.

module double_to_sig16b (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] double,
    output logic [15:0] sig16b,
    output logic        stop,
    output logic        ovf
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLASSIFY = 3'd1,
        SHIFT    = 3'd2,
        ROUND    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        sgn, sgn_nxt;
    logic [10:0] exp_r, exp_nxt;
    logic [15:0] sig, sig_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        guard, guard_nxt;
    logic        pend_ovf, pend_ovf_nxt;
    logic [15:0] sig16b_nxt;
    logic        stop_nxt, ovf_nxt;

    logic        rnd;
    logic [15:0] sum;
    logic [14:0] mag;
    logic        sum_ovf;

    // Low fraction bits carry no weight in a 16-bit result.
    logic        unused_bits;
    assign unused_bits = ^double[36:0];

`ifdef D2S_ROUND_EN
    assign rnd = guard;
    localparam logic [15:0] HALF_MAG = 16'h0001;
`else
    logic        unused_guard;
    assign unused_guard = guard;
    assign rnd = 1'b0;
    localparam logic [15:0] HALF_MAG = 16'h0000;
`endif

    assign sum     = {1'b0, sig[14:0]} + {15'd0, rnd};
    assign sum_ovf = sum[15];
    assign mag     = sum_ovf ? 15'h7FFF : sum[14:0];

    always_comb begin
        state_nxt    = state;
        sgn_nxt      = sgn;
        exp_nxt      = exp_r;
        sig_nxt      = sig;
        cnt_nxt      = cnt;
        guard_nxt    = guard;
        pend_ovf_nxt = pend_ovf;
        sig16b_nxt   = sig16b;
        stop_nxt     = stop;
        ovf_nxt      = ovf;

        if (start) begin
            // Restart from any state; old sig16b/ovf stay visible until overwritten.
            state_nxt    = CLASSIFY;
            sgn_nxt      = double[63];
            exp_nxt      = double[62:52];
            sig_nxt      = {1'b1, double[51:37]};
            cnt_nxt      = 4'd0;
            guard_nxt    = 1'b0;
            pend_ovf_nxt = 1'b0;
            stop_nxt     = 1'b0;
        end else begin
            case (state)
                CLASSIFY: begin
                    // Special results are preloaded into sig with guard=0 and committed
                    // by ROUND, so every result leaves through a single write point.
                    guard_nxt    = 1'b0;
                    pend_ovf_nxt = 1'b0;
                    state_nxt    = ROUND;
                    if (exp_r == 11'h7FF && sig[14:0] != 15'd0) begin
                        sig_nxt      = 16'h0000;
                        sgn_nxt      = 1'b0;
                        pend_ovf_nxt = 1'b1;
                    end else if (exp_r >= 11'd1038) begin
                        // Inf and E>=15 both saturate with the operand sign.
                        sig_nxt      = 16'h7FFF;
                        pend_ovf_nxt = 1'b1;
                    end else if (exp_r <= 11'd1021) begin
                        sig_nxt = 16'h0000;
                    end else if (exp_r == 11'd1022) begin
                        sig_nxt = HALF_MAG;
                    end else begin
                        // cnt = 15-E = 1038-e; 1038 mod 16 = 14 and the result fits in 4 bits.
                        cnt_nxt   = 4'd14 - exp_r[3:0];
                        state_nxt = SHIFT;
                    end
                end
                SHIFT: begin
                    sig_nxt   = sig >> 1;
                    guard_nxt = sig[0];
                    cnt_nxt   = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = ROUND;
                end
                ROUND: begin
                    sig16b_nxt = {sgn & (mag != 15'd0), mag};
                    ovf_nxt    = pend_ovf | sum_ovf;
                    stop_nxt   = 1'b1;
                    state_nxt  = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sgn      <= 1'b0;
            exp_r    <= 11'd0;
            sig      <= 16'd0;
            cnt      <= 4'd0;
            guard    <= 1'b0;
            pend_ovf <= 1'b0;
            sig16b   <= 16'h0000;
            stop     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            sgn      <= sgn_nxt;
            exp_r    <= exp_nxt;
            sig      <= sig_nxt;
            cnt      <= cnt_nxt;
            guard    <= guard_nxt;
            pend_ovf <= pend_ovf_nxt;
            sig16b   <= sig16b_nxt;
            stop     <= stop_nxt;
            ovf      <= ovf_nxt;
        end
    end

endmodule

// File: doc/double_to_sig16b.md
# double_to_sig16b

Converts an IEEE-754 double-precision word back into the 16-bit sign-magnitude sample format used on the signal path. It is the return leg of the 16-bit-to-double front-end conversion: the echo-cancellation datapath computes in double, and this block turns results back into codec samples. The conversion is multi-cycle and shifts one bit per cycle. It saturates out-of-range values and flags them.

## Interface
- No parameters.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset; overrides every other input.
- start  input  1  one-cycle load strobe; samples `double`.
- double  input  64  IEEE-754 double operand.
- sig16b  output  16  result: [15] sign, [14:0] magnitude.
- stop  output  1  done flag; stays high until the next start or rst.
- ovf  output  1  saturation/invalid flag, valid while stop=1.

## Operation
- Latched fields on start: `s`=double[63], `e`=double[62:52], significand S={1'b1,double[51:37]} (16 b). Bits [36:0] are ignored.
- The unbiased exponent is E=e-1023. The intended value is S·2^(E-15).
- FSM states and transitions:
  - IDLE: waits for start.
  - CLASSIFY: picks the conversion path.
  - SHIFT: shifts S right.
  - ROUND: applies rounding and writes the result.
  - DONE: holds the result.
  - A start in any state goes to CLASSIFY.
- CLASSIFY cases (first match wins):
  - e=2047, fraction≠0 (NaN): mag=0, sign=0, ovf=1, go to DONE.
  - e=2047, fraction=0 (Inf): mag=0x7FFF, sign=s, ovf=1, go to DONE.
  - E≥15: mag=0x7FFF, sign=s, ovf=1, go to DONE.
  - e=0 (zero or subnormal): mag=0, go to DONE.
  - E≤-2: mag=0, go to DONE.
  - E=-1: mag=1 if D2S_ROUND_EN is defined, else 0; go to DONE.
  - 0≤E≤14: cnt=15-E, go to SHIFT.
- SHIFT: each cycle does S<=S>>1 and guard<=S[0], then cnt<=cnt-1. Leaves for ROUND when cnt reaches 0. Occupancy is exactly 15-E cycles.
- ROUND:
  - mag=S[14:0]+(guard if rounding is enabled).
  - If the sum is 32768 (E=14, S all ones, guard=1): mag=0x7FFF, ovf=1.
  - Then go to DONE.
- Sign rule: when mag=0, sig16b[15] is forced to 0, so -0.0 and tiny negatives give 0x0000.
- sig16b, ovf and stop update together on the same edge. They hold in DONE and IDLE until the next start.
- start while busy aborts the running conversion and restarts with the new operand. It clears stop on that edge; sig16b and ovf keep their old values until the new result is written.

## Timing
- Reset values: sig16b=0x0000, stop=0, ovf=0, FSM=IDLE, cnt=0, guard=0.
- rst asserted mid-conversion returns to IDLE; no partial result is ever emitted.
- Latency is counted in edges, from the edge that samples start to the edge that sets stop:
  - special or out-of-range paths: 2.
  - normal path: 17-E, i.e. 3 for E=14 and 17 for E=0.
- stop is a level, not a pulse. Consumers sample sig16b on the first cycle stop=1.
- There is no back-pressure. start is accepted every cycle, including the cycle stop rises.

## Configuration
- D2S_ROUND_EN defined: round to nearest, ties away from zero, using the guard bit. E=-1 gives magnitude 1. Rounding can overflow to 32768, which saturates to 0x7FFF with ovf=1.
- D2S_ROUND_EN undefined: truncation toward zero. The guard bit is unused, E=-1 gives 0, and the ROUND-overflow case cannot occur.
- Latency is identical with and without the macro.

## Test plan
- 0x3FF0000000000000 (1.0) -> sig16b=0x0001, ovf=0, stop rises 17 edges after start.
- 0x408F400000000000 (1000.0) -> 0x03E8 after 8 edges; 0xC0DFFFC000000000 (-32767.0) -> 0xFFFF after 3 edges.
- 0x40E3880000000000 (40000.0) -> 0x7FFF, ovf=1 after 2 edges; 0x7FF8000000000000 (NaN) -> 0x0000, ovf=1; 0x8000000000000000 (-0.0) -> 0x0000, ovf=0.
- 0x4004000000000000 (2.5) -> 0x0003 with D2S_ROUND_EN, 0x0002 without. 0x40DFFFE000000000 (32767.5) -> 0x7FFF with ovf=1 with the macro; 0x7FFF with ovf=0 without.
- Abort and reset:
  - start 1.0, then at edge 5 start 1000.0 -> stop drops at edge 5 and rises 8 edges later with 0x03E8; no 0x0001 is ever flagged.
  - Separately, rst during SHIFT -> all outputs 0 on the next edge.
- Back-to-back: start asserted on the cycle stop rises -> stop clears next edge and the new result follows with the correct latency.
